// File: rtl/pong_engine_p.sv
// Pong game core: PS/2 make/break key decoding, per-frame game FSM (physics, AI, scoring) and pixel colour.
// Latency: game state changes only on the frame_tick cycle; colour is registered one cycle after the pixel inputs.
// Backpressure: none; every key byte and frame tick is accepted on the cycle it is presented.
`timescale 1ns/1ps
module pong_engine_p #(
  parameter int COORD_W       = 10,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int PADDLE_W      = 64,
  parameter int PADDLE_H      = 8,
  parameter int BALL_SZ       = 8,
  parameter int STEP          = 8,
  parameter int BORDER        = 6,
  parameter int FEATURE       = 11,
  parameter int WIN_SCORE     = 9,
  parameter int BALL_DIV_INIT = 5,
  parameter int BALL_DIV_MIN  = 1,
  parameter int AI_DIV        = 4,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic               active_zone,
  input  logic [COORD_W-1:0] x_pos,
  input  logic [COORD_W-1:0] y_pos,
  output logic [11:0]        color,
  output logic [3:0]         score_p1,
  output logic [3:0]         score_p2,
  output logic [2:0]         game_state,
  output logic [1:0]         winner
);
  localparam int W = COORD_W;

  typedef enum logic [2:0] {S_INIT = 3'd0, S_SELECT = 3'd1, S_SERVE = 3'd2,
                            S_PLAY = 3'd3, S_PAUSE = 3'd4, S_OVER = 3'd5} state_t;
  typedef enum logic [2:0] {C_NONE, C_ONE, C_TWO, C_SPACE, C_ESC} cmd_t;

  // Signed geometry limits (W+1 bits so differences never wrap)
  localparam logic signed [W:0] STEP_S  = (W+1)'(STEP);
  localparam logic signed [W:0] PAD_LO  = (W+1)'(FEATURE + PADDLE_W/2);
  localparam logic signed [W:0] PAD_HI  = (W+1)'(SCREEN_W - FEATURE - PADDLE_W/2);
  localparam logic signed [W:0] BX_LO   = (W+1)'(FEATURE + BALL_SZ/2);
  localparam logic signed [W:0] BX_HI   = (W+1)'(SCREEN_W - FEATURE - BALL_SZ/2);
  localparam logic signed [W:0] HB      = (W+1)'(BALL_SZ/2);
  localparam logic signed [W:0] P1_TOP  = (W+1)'(SCREEN_H - 4*BORDER - PADDLE_H/2);
  localparam logic signed [W:0] P2_BOT  = (W+1)'(4*BORDER + PADDLE_H/2);
  localparam logic signed [W:0] BOT_LIM = (W+1)'(SCREEN_H - FEATURE);
  localparam logic signed [W:0] TOP_LIM = (W+1)'(FEATURE);
  localparam logic [W:0]   REACH   = (W+1)'(PADDLE_W/2 + BALL_SZ/2);
  localparam logic [W:0]   PW_H    = (W+1)'(PADDLE_W/2);
  localparam logic [W:0]   PH_H    = (W+1)'(PADDLE_H/2);
  localparam logic [W:0]   BS_H    = (W+1)'(BALL_SZ/2);
  localparam logic [W-1:0] P1_Y    = W'(SCREEN_H - 4*BORDER);
  localparam logic [W-1:0] P2_Y    = W'(4*BORDER);
  localparam logic [W-1:0] Y_HIT1  = W'(SCREEN_H - 4*BORDER - PADDLE_H/2 - BALL_SZ/2);
  localparam logic [W-1:0] Y_HIT2  = W'(4*BORDER + PADDLE_H/2 + BALL_SZ/2);
  localparam logic [W-1:0] CX      = W'(SCREEN_W/2);
  localparam logic [W-1:0] CY      = W'(SCREEN_H/2);
  localparam logic [W-1:0] BRD     = W'(BORDER);
  localparam logic [W-1:0] FEA     = W'(FEATURE);
  localparam logic [W-1:0] X_BRD   = W'(SCREEN_W - 1 - BORDER);
  localparam logic [W-1:0] Y_BRD   = W'(SCREEN_H - 1 - BORDER);
  localparam logic [W-1:0] X_FEA   = W'(SCREEN_W - 1 - FEATURE);
  localparam logic [W-1:0] Y_FEA   = W'(SCREEN_H - 1 - FEATURE);
  localparam logic [7:0]   DIV_INIT = 8'(BALL_DIV_INIT);
  localparam logic [7:0]   DIV_MIN  = 8'(BALL_DIV_MIN);
  localparam logic [7:0]   AI_LAST  = 8'(AI_DIV - 1);
  localparam logic [15:0]  SERVE_LAST = 16'(SERVE_FRAMES - 1);
  localparam logic [3:0]   WIN_M1   = 4'(WIN_SCORE - 1);
  localparam logic [11:0]  BLACK = 12'h000, WHITE = 12'hFFF, RED = 12'hF00, PINK = 12'hE76;

  state_t         state;
  cmd_t           cmd;
  logic           hold_a, hold_d, hold_j, hold_l, break_pending, multi;
  logic [W-1:0]   ball_x, ball_y, p1_x, p2_x;
  logic           dx, dy;
  logic [7:0]     ball_div, ball_cnt, ai_cnt;
  logic [15:0]    serve_cnt;

  // Next-step values
  logic signed [W:0] bx_s, by_s;
  logic [W-1:0]      bx_n, by_n, p1_nx, p2_key_nx, p2_ai_nx;
  logic              dx_n, hit, miss_bot, miss_top;
  logic [7:0]        div_dec;
  logic              in_p1, in_p2, in_ball, in_border, in_band;

  function automatic logic signed [W:0] sx(input logic [W-1:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic [W:0] absd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] d;
    d = sx(a) - sx(b);
    return (d < 0) ? -d : d;
  endfunction

  // One paddle step; opposite directions cancel, overshoot lands on the limit
  function automatic logic [W-1:0] pad_move(input logic [W-1:0] x, input logic neg, input logic pos);
    logic signed [W:0] n;
    n = sx(x);
    if (neg && !pos)      n = n - STEP_S;
    else if (pos && !neg) n = n + STEP_S;
    if (n < PAD_LO)      n = PAD_LO;
    else if (n > PAD_HI) n = PAD_HI;
    return n[W-1:0];
  endfunction

  // Candidate ball step, paddle moves and collision tests from the current state
  always_comb begin
    p1_nx     = pad_move(p1_x, hold_a, hold_d);
    p2_key_nx = pad_move(p2_x, hold_j, hold_l);
    p2_ai_nx  = pad_move(p2_x, ball_x < p2_x, ball_x > p2_x);
    bx_s = dx ? sx(ball_x) + STEP_S : sx(ball_x) - STEP_S;
    by_s = dy ? sx(ball_y) + STEP_S : sx(ball_y) - STEP_S;
    bx_n = bx_s[W-1:0];
    dx_n = dx;
    if (bx_s < BX_LO || bx_s > BX_HI) begin
      bx_n = ball_x;
      dx_n = ~dx;
    end
    miss_bot = 1'b0;
    miss_top = 1'b0;
    if (dy) begin
      hit      = (by_s + HB >= P1_TOP) && (absd(ball_x, p1_x) <= REACH);
      miss_bot = !hit && (by_s + HB >= BOT_LIM);
      by_n     = hit ? Y_HIT1 : by_s[W-1:0];
    end else begin
      hit      = (by_s - HB <= P2_BOT) && (absd(ball_x, p2_x) <= REACH);
      miss_top = !hit && (by_s - HB <= TOP_LIM);
      by_n     = hit ? Y_HIT2 : by_s[W-1:0];
    end
    div_dec = (ball_div > DIV_MIN) ? ball_div - 8'd1 : DIV_MIN;
  end

  // PS/2 decoder: held movement flags plus a one-deep command latch consumed by frame_tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_a <= 1'b0; hold_d <= 1'b0; hold_j <= 1'b0; hold_l <= 1'b0;
      break_pending <= 1'b0;
      cmd <= C_NONE;
    end else begin
      if (frame_tick) cmd <= C_NONE;
      if (key_valid) begin
        if (key_code == 8'hF0) begin
          break_pending <= 1'b1;
        end else begin
          break_pending <= 1'b0;
          case (key_code)
            8'h1C: hold_a <= !break_pending;
            8'h23: hold_d <= !break_pending;
            8'h3B: hold_j <= !break_pending;
            8'h4B: hold_l <= !break_pending;
            8'h16: if (!break_pending) cmd <= C_ONE;
            8'h1E: if (!break_pending) cmd <= C_TWO;
            8'h29: if (!break_pending) cmd <= C_SPACE;
            8'h76: if (!break_pending) cmd <= C_ESC;
            default: ;
          endcase
        end
      end
    end
  end

  // Game FSM: all state, physics and scoring advance once per frame_tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_INIT; score_p1 <= 4'd0; score_p2 <= 4'd0; winner <= 2'b00; multi <= 1'b0;
      ball_x <= CX; ball_y <= CY; p1_x <= CX; p2_x <= CX; dx <= 1'b1; dy <= 1'b1;
      ball_div <= DIV_INIT; ball_cnt <= 8'd0; ai_cnt <= 8'd0; serve_cnt <= 16'd0;
    end else if (frame_tick) begin
      if (state == S_INIT) begin
        ball_x <= CX; ball_y <= CY; p1_x <= CX; p2_x <= CX; ball_div <= DIV_INIT;
        score_p1 <= 4'd0; score_p2 <= 4'd0; winner <= 2'b00; state <= S_SELECT;
      end else if (cmd == C_ESC) begin
        state <= S_INIT;
      end else begin
        case (state)
          S_SELECT: begin
            if (cmd == C_ONE)      multi <= 1'b0;
            else if (cmd == C_TWO) multi <= 1'b1;
            else if (cmd == C_SPACE) begin
              state <= S_SERVE; dx <= 1'b1; dy <= 1'b1;
              serve_cnt <= 16'd0; ball_cnt <= 8'd0; ai_cnt <= 8'd0;
            end
          end
          S_SERVE: begin
            p1_x <= p1_nx;
            if (multi) p2_x <= p2_key_nx;
            if (serve_cnt == SERVE_LAST) state <= S_PLAY;
            else serve_cnt <= serve_cnt + 16'd1;
          end
          S_PLAY: begin
            if (cmd == C_SPACE) begin
              state <= S_PAUSE;
            end else begin
              p1_x <= p1_nx;
              if (multi) p2_x <= p2_key_nx;
              else if (ai_cnt == AI_LAST) p2_x <= p2_ai_nx;
              ai_cnt <= (ai_cnt == AI_LAST) ? 8'd0 : ai_cnt + 8'd1;
              if (ball_cnt == ball_div - 8'd1) begin
                ball_cnt <= 8'd0;
                dx <= dx_n;
                if (miss_bot || miss_top) begin
                  ball_x <= CX; ball_y <= CY; ball_div <= DIV_INIT;
                  ai_cnt <= 8'd0; serve_cnt <= 16'd0; state <= S_SERVE;
                  if (miss_bot) begin
                    score_p2 <= score_p2 + 4'd1;
                    if (score_p2 == WIN_M1) begin state <= S_OVER; winner <= 2'b10; end
                  end else begin
                    score_p1 <= score_p1 + 4'd1;
                    if (score_p1 == WIN_M1) begin state <= S_OVER; winner <= 2'b01; end
                  end
                end else begin
                  ball_x <= bx_n;
                  ball_y <= by_n;
                  if (hit) begin dy <= ~dy; ball_div <= div_dec; end
                end
              end else begin
                ball_cnt <= ball_cnt + 8'd1;
              end
            end
          end
          S_PAUSE: if (cmd == C_SPACE) state <= S_PLAY;
          S_OVER:  if (cmd == C_SPACE) state <= S_INIT;
          default: state <= S_INIT;
        endcase
      end
    end
  end

  // Pixel classification against sprites and screen-edge bands
  always_comb begin
    in_p1     = (absd(x_pos, p1_x) <= PW_H) && (absd(y_pos, P1_Y) <= PH_H);
    in_p2     = (absd(x_pos, p2_x) <= PW_H) && (absd(y_pos, P2_Y) <= PH_H);
    in_ball   = (absd(x_pos, ball_x) <= BS_H) && (absd(y_pos, ball_y) <= BS_H);
    in_border = (x_pos <= BRD) || (y_pos <= BRD) || (x_pos >= X_BRD) || (y_pos >= Y_BRD);
    in_band   = (x_pos <= FEA) || (y_pos <= FEA) || (x_pos >= X_FEA) || (y_pos >= Y_FEA);
  end

  // Registered colour with fixed draw priority
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                            color <= BLACK;
    else if (!active_zone)                 color <= BLACK;
    else if (in_p1)                        color <= RED;
    else if (in_p2)                        color <= (state == S_SELECT && !multi) ? BLACK : RED;
    else if (in_ball && state != S_OVER)   color <= WHITE;
    else if (in_border)                    color <= WHITE;
    else if (in_band)                      color <= PINK;
    else                                   color <= BLACK;
  end

  assign game_state = state;
endmodule

// File: tb/tb_pong_engine_p.sv
// Bench for pong_engine_p: random key/frame stimulus against a behavioural game model.
// Expected frame results and pixel colours are queued at stimulus time and popped by a monitor.
// Game positions are compared through hierarchical references to the design's state.
`timescale 1ns/1ps
module tb_pong_engine_p;
  logic        clock = 1'b0, reset = 1'b1, frame_tick = 1'b0, key_valid = 1'b0, active_zone = 1'b0;
  logic [7:0]  key_code = 8'd0;
  logic [9:0]  x_pos = 10'd0, y_pos = 10'd0;
  logic [11:0] color;
  logic [3:0]  score_p1, score_p2;
  logic [2:0]  game_state;
  logic [1:0]  winner;

  pong_engine_p dut (.clock(clock), .reset(reset), .frame_tick(frame_tick), .key_valid(key_valid),
                     .key_code(key_code), .active_zone(active_zone), .x_pos(x_pos), .y_pos(y_pos),
                     .color(color), .score_p1(score_p1), .score_p2(score_p2),
                     .game_state(game_state), .winner(winner));

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  // Behavioural game model (states numbered 0 INIT .. 5 OVER)
  int m_st, m_s1, m_s2, m_win, m_bx, m_by, m_p1, m_p2, m_div, m_bcnt, m_acnt, m_scnt, m_cmd;
  bit m_dx, m_dy, m_multi, m_a, m_d, m_j, m_l, m_brk;

  typedef struct {int st; int s1; int s2; int win; int bx; int by; int p1; int p2; int div;} snap_t;
  snap_t st_q[$];
  int    col_q[$];
  logic  pix_vld = 1'b0, pv_d = 1'b0, tick_d = 1'b0;
  snap_t mon_s;
  int    mon_e;
  int    codes[4] = '{'h1C, 'h23, 'h3B, 'h4B};

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction

  // Paddle centre after one press step, kept inside the play field
  function automatic int pmove(int x, bit left, bit right);
    int n = x;
    if (left && !right) n = x - 8;
    if (right && !left) n = x + 8;
    if (n < 43)  n = 43;
    if (n > 597) n = 597;
    return n;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_bx = 320; m_by = 240; m_p1 = 320; m_p2 = 320;
    m_div = 5; m_bcnt = 0; m_acnt = 0; m_scnt = 0; m_cmd = 0; m_dx = 1; m_dy = 1;
    m_multi = 0; m_a = 0; m_d = 0; m_j = 0; m_l = 0; m_brk = 0;
  endfunction

  function automatic void model_key(int b);
    if (b == 'hF0) m_brk = 1;
    else begin
      case (b)
        'h1C: m_a = !m_brk;
        'h23: m_d = !m_brk;
        'h3B: m_j = !m_brk;
        'h4B: m_l = !m_brk;
        'h16, 'h1E, 'h29, 'h76: if (!m_brk) m_cmd = b;
        default: ;
      endcase
      m_brk = 0;
    end
  endfunction

  // Ball advance; collisions judged against where the paddles were at the start of the frame
  function automatic void ball_step(int p1_old, int p2_old);
    int  nx = m_bx + (m_dx ? 8 : -8);
    int  ny = m_by + (m_dy ? 8 : -8);
    bit  hit, miss;
    if (nx < 15 || nx > 625) begin nx = m_bx; m_dx = !m_dx; end
    if (m_dy) begin
      hit  = (ny + 4 >= 452) && (iabs(m_bx - p1_old) <= 36);
      miss = !hit && (ny + 4 >= 469);
    end else begin
      hit  = (ny - 4 <= 28) && (iabs(m_bx - p2_old) <= 36);
      miss = !hit && (ny - 4 <= 11);
    end
    if (miss) begin
      if (m_dy) m_s2++; else m_s1++;
      m_bx = 320; m_by = 240; m_div = 5; m_acnt = 0; m_scnt = 0; m_st = 2;
      if (m_s2 == 9) begin m_st = 5; m_win = 2; end
      if (m_s1 == 9) begin m_st = 5; m_win = 1; end
    end else begin
      m_bx = nx;
      if (hit) begin
        m_by = m_dy ? 448 : 32;
        m_dy = !m_dy;
        m_div = (m_div > 1) ? m_div - 1 : 1;
      end else m_by = ny;
    end
  endfunction

  function automatic void model_tick();
    int c = m_cmd;
    int bx_old = m_bx, p1_old = m_p1, p2_old = m_p2;
    m_cmd = 0;
    if (m_st == 0) begin
      m_bx = 320; m_by = 240; m_p1 = 320; m_p2 = 320; m_div = 5;
      m_s1 = 0; m_s2 = 0; m_win = 0; m_st = 1;
    end else if (c == 'h76) m_st = 0;
    else if (m_st == 1) begin
      if (c == 'h16) m_multi = 0;
      if (c == 'h1E) m_multi = 1;
      if (c == 'h29) begin m_st = 2; m_dx = 1; m_dy = 1; m_scnt = 0; m_bcnt = 0; m_acnt = 0; end
    end else if (m_st == 2) begin
      m_p1 = pmove(p1_old, m_a, m_d);
      if (m_multi) m_p2 = pmove(p2_old, m_j, m_l);
      if (m_scnt == 59) m_st = 3; else m_scnt++;
    end else if (m_st == 3) begin
      if (c == 'h29) m_st = 4;
      else begin
        m_p1 = pmove(p1_old, m_a, m_d);
        if (m_multi) m_p2 = pmove(p2_old, m_j, m_l);
        else if (m_acnt == 3) m_p2 = pmove(p2_old, bx_old < p2_old, bx_old > p2_old);
        m_acnt = (m_acnt + 1) % 4;
        if (m_bcnt < m_div - 1) m_bcnt++;
        else begin m_bcnt = 0; ball_step(p1_old, p2_old); end
      end
    end else if (m_st == 4) begin
      if (c == 'h29) m_st = 3;
    end else if (m_st == 5) begin
      if (c == 'h29) m_st = 0;
    end
  endfunction

  function automatic int exp_color(int x, int y, bit act);
    int e;
    if (!act) return 'h000;
    if (iabs(x - m_p1) <= 32 && iabs(y - 456) <= 4) return 'hF00;
    if (iabs(x - m_p2) <= 32 && iabs(y - 24) <= 4) return (m_st == 1 && !m_multi) ? 'h000 : 'hF00;
    if (m_st != 5 && iabs(x - m_bx) <= 4 && iabs(y - m_by) <= 4) return 'hFFF;
    e = x;
    if (639 - x < e) e = 639 - x;
    if (y < e) e = y;
    if (479 - y < e) e = 479 - y;
    if (e <= 6)  return 'hFFF;
    if (e <= 11) return 'hE76;
    return 'h000;
  endfunction

  // Stimulus tasks: entered and left one time unit after a rising edge
  task automatic tick();
    frame_tick = 1'b1;
    model_tick();
    st_q.push_back('{m_st, m_s1, m_s2, m_win, m_bx, m_by, m_p1, m_p2, m_div});
    @(posedge clock); #1 frame_tick = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic key(int b);
    key_valid = 1'b1; key_code = b[7:0];
    model_key(b);
    @(posedge clock); #1 key_valid = 1'b0;
  endtask

  task automatic press(int code, bit on);
    if (!on) key('hF0);
    key(code);
  endtask

  task automatic set_p1(bit a, bit d);
    if (a != m_a) press('h1C, a);
    if (d != m_d) press('h23, d);
  endtask

  task automatic probe(int x, int y, bit act);
    active_zone = act; x_pos = x[9:0]; y_pos = y[9:0]; pix_vld = 1'b1;
    col_q.push_back(exp_color(x, y, act));
    @(posedge clock); #1 pix_vld = 1'b0; active_zone = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the design presents a colour or a frame result
  always @(posedge clock) begin
    tick_d <= frame_tick;
    pv_d   <= pix_vld;
  end

  always @(negedge clock) begin
    if (pv_d) begin
      if (col_q.size() == 0) chk("color_queue_underflow", 1, 0);
      else begin mon_e = col_q.pop_front(); chk("color", int'(color), mon_e); end
    end
    if (tick_d) begin
      if (st_q.size() == 0) chk("frame_queue_underflow", 1, 0);
      else begin
        mon_s = st_q.pop_front();
        chk("game_state", int'(game_state), mon_s.st);
        chk("score_p1", int'(score_p1), mon_s.s1);
        chk("score_p2", int'(score_p2), mon_s.s2);
        chk("winner", int'(winner), mon_s.win);
        chk("ball_x", int'(dut.ball_x), mon_s.bx);
        chk("ball_y", int'(dut.ball_y), mon_s.by);
        chk("p1_x", int'(dut.p1_x), mon_s.p1);
        chk("p2_x", int'(dut.p2_x), mon_s.p2);
        chk("ball_div", int'(dut.ball_div), mon_s.div);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int over_frames;
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_state", int'(game_state), 0);
    chk("reset_score_p1", int'(score_p1), 0);
    chk("reset_score_p2", int'(score_p2), 0);
    chk("reset_winner", int'(winner), 0);
    chk("reset_color", int'(color), 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;

    // SELECT screen: single mode hides p2, then colour bands and blanking
    tick();
    probe(m_p2, 24, 1); probe(m_p1, 456, 1); probe(m_p1 + 32, 460, 1); probe(m_p1 + 33, 456, 1);
    probe(3, 200, 1); probe(8, 200, 1); probe(12, 200, 1); probe(m_p1, 456, 0);
    probe(320, 240, 1); probe(324, 244, 1); probe(325, 240, 1); probe(634, 100, 1);
    key('h1E); tick();
    probe(m_p2, 24, 1);
    key('h29); tick();
    key('h29);                       // ignored while serving
    repeat (60) tick();

    // Hold A until p1 clamps at the left limit, then release
    press('h1C, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 4 == 0) begin probe(m_p1 + 32, 456, 1); probe(m_p1 + 33, 456, 1); end
    end
    press('h1C, 0); tick();

    // Random key traffic in multi mode
    for (int f = 0; f < 400; f++) begin
      int r = $urandom_range(0, 19);
      if (r < 8) press(codes[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
      else if (r == 8) key('h29);
      else if (r == 9) key('h16);
      else if (r == 10) begin key('hF0); key('h29); end
      tick();
      probe(m_bx, m_by, 1);
      probe($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 3) != 0));
      probe(m_p2 - 32 - (f % 2), 24 + 4, 1);
    end

    // Back to SELECT in single mode; p1 flees the ball so the computer wins rounds
    key('h76); tick(); tick();
    if (m_j) press('h3B, 0);
    if (m_l) press('h4B, 0);
    key('h16); tick();
    probe(m_p2, 24, 1);
    key('h29); tick();
    over_frames = 0;
    while (m_st != 5 && over_frames < 6000) begin
      set_p1(m_bx >= 320, m_bx < 320);
      tick();
      if (over_frames % 16 == 0) probe(m_bx, m_by, 1);
      over_frames++;
    end
    @(negedge clock);
    chk("reached_over", int'(game_state), 5);
    @(posedge clock); #1;
    probe(m_bx, m_by, 1);            // ball hidden once the game is over
    probe(m_p1, 456, 1);
    key('h29); tick(); tick();

    // Reset in the middle of PLAY
    key('h29); tick();
    repeat (65) tick();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    chk("midplay_reset_state", int'(game_state), 0);
    chk("midplay_reset_score_p1", int'(score_p1), 0);
    chk("midplay_reset_score_p2", int'(score_p2), 0);
    chk("midplay_reset_color", int'(color), 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    tick();
    probe(m_p1, 456, 1); probe(m_bx, m_by, 1);

    repeat (4) @(posedge clock);
    chk("color_queue_drained", col_q.size(), 0);
    chk("frame_queue_drained", st_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_engine_p.md
Name: pong_engine_p

Overview:
- Parametrised next-generation Pong game core. Sits between the PS/2 scan-code receiver and the VGA timing generator.
- Owns game state, physics, scoring and per-pixel colour.
- Generalises screen, sprite, speed and win-score geometry.
- Adds held-key continuous paddle motion (make/break decoding), a serve countdown, a game-over state with winner report, and explicit frame-tick timing.

Parameters:
- COORD_W, 10, width of all coordinates
- SCREEN_W, 640, visible width (px)
- SCREEN_H, 480, visible height (px)
- PADDLE_W, 64, paddle width
- PADDLE_H, 8, paddle height
- BALL_SZ, 8, ball side
- STEP, 8, px moved per ball/paddle step
- BORDER, 6, white border thickness
- FEATURE, 11, outer edge of pink band (play-field limit)
- WIN_SCORE, 9, points to win, max 15
- BALL_DIV_INIT, 5, frames per ball step at serve
- BALL_DIV_MIN, 1, fastest ball divider
- AI_DIV, 4, frames per computer paddle step
- SERVE_FRAMES, 60, countdown frames before ball launches

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame, outside active video
- key_valid  in  1  one-cycle strobe: key_code holds a new PS/2 byte
- key_code  in  8  PS/2 set-2 scan-code byte
- active_zone  in  1  pixel is in visible area
- x_pos  in  COORD_W  current pixel x
- y_pos  in  COORD_W  current pixel y
- color  out  12  RGB444 pixel colour, registered
- score_p1  out  4  player-1 (bottom) score
- score_p2  out  4  player-2 / computer (top) score
- game_state  out  3  current FSM state encoding
- winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (async, active-low) forces:
  - state INIT; scores 0; winner 00; color 0.
  - All held-key flags 0; break_pending 0; counters 0; mode single.
- Key decoder, evaluated on every key_valid:
  - Byte F0 sets break_pending.
  - Next byte clears held flag A(1C)/D(23)/J(3B)/L(4B) if break_pending, else sets it; break_pending then clears.
  - Command keys act on make only: 1(16), 2(1E), SPACE(29), ESC(76). They latch into a one-deep cmd register, consumed at the next frame_tick; a newer command overwrites.
- All game updates happen only on the frame_tick cycle.
- States: INIT=0, SELECT=1, SERVE=2, PLAY=3, PAUSE=4, OVER=5.
  - INIT: center ball at (SCREEN_W/2, SCREEN_H/2); paddles at x=SCREEN_W/2, p2_y=4*BORDER, p1_y=SCREEN_H-4*BORDER; ball_div=BALL_DIV_INIT; scores 0; winner 00; next state SELECT.
  - SELECT: key 1 sets single mode, key 2 sets multi mode; SPACE goes to SERVE with dx=1, dy=1, serve_cnt=0.
  - SERVE: paddles move; ball frozen. serve_cnt increments; at SERVE_FRAMES-1 go to PLAY. SPACE is ignored.
  - PLAY: paddles move, ball moves, AI runs; SPACE goes to PAUSE.
  - PAUSE: everything frozen; SPACE returns to PLAY.
  - OVER: everything frozen; SPACE goes to INIT.
  - ESC in any state except INIT goes to INIT.
- Paddle motion, per frame while a key is held:
  - A/D moves p1 ±STEP. J/L moves p2 ±STEP, multi mode only.
  - Both directions held: no motion.
  - Centre x is clamped to [FEATURE+PADDLE_W/2, SCREEN_W-FEATURE-PADDLE_W/2] (43..597 default). A step that would overshoot lands exactly on the limit.
- AI (single mode, PLAY only): every AI_DIV frames, p2 moves STEP toward ball_x; clamped the same way; no move if equal.
- Ball motion, PLAY only, every ball_div frames:
  - X: next x = x±STEP. If it would pass FEATURE+BALL_SZ/2 or SCREEN_W-FEATURE-BALL_SZ/2, flip dx and hold x.
  - Y down: if ball bottom ≥ p1 top and |ball_x-p1_x| ≤ PADDLE_W/2+BALL_SZ/2, it is a hit:
    - dy=0; ball_y = p1_y-PADDLE_H/2-BALL_SZ/2.
    - ball_div = max(ball_div-1, BALL_DIV_MIN).
  - Y up: symmetric test against p2.
  - Miss: ball edge reaches SCREEN_H-FEATURE (bottom) or FEATURE (top).
    - Opponent scores +1.
    - Ball re-centres; dy points toward the conceding player; ball_div=BALL_DIV_INIT.
    - Next state is SERVE, or OVER with winner set if the new score equals WIN_SCORE.
    - Hit and miss on the same step: hit wins.
- Differences are computed at COORD_W+1 bits signed; there is no wrap.
- Render, every cycle, 1-cycle latency. Priority order:
  1. !active_zone gives black.
  2. p1 paddle, red.
  3. p2 paddle, red; black in SELECT while single mode.
  4. Ball, white; hidden in OVER.
  5. Edge ≤ BORDER, white.
  6. Edge ≤ FEATURE, pink (E76).
  7. Else black.
  - Sprite rectangles are inclusive of centre ±half-size.

Test Plan:
- Reset low mid-PLAY → next edge: game_state=0, scores 0, color 0. Release, 1 tick → game_state=1; ball (320,240), p1 (320,456), p2 (320,24).
- SELECT, key 2 then SPACE, 60 ticks → game_state=3. Hold A (1C) 40 ticks → p1_x=43, clamped. Send F0 1C, 1 tick → p1_x stays 43.
- Single mode, ball_x=400 held, p2_x=320 → after 4 ticks p2_x=328, after 8 ticks 336.
- Force ball onto p1 (x=330, descending): dy=0, ball_div 5→4. Repeat until ball_div stays 1.
- score_p2=8, ball misses bottom → score_p2=9, winner=10, game_state=5, ball hidden. SPACE → game_state=0, then 1.
- Pixel (3,200) active → white; (8,200) → pink; pixel on p1 → E-less red F00; active_zone=0 → 000, one cycle later.
